// File: rtl/hsv_core_issue_scoreboard.sv
// Issue/commit register-write scoreboard: per-register in-flight counters, busy mask and hazard query.
// Optional sticky protocol-error detection is enabled with `define HSV_SCOREBOARD_ERR_EN.
module hsv_core_issue_scoreboard #(
  parameter int CNT_W = 2
) (
  input  logic        clk_core,
  input  logic        rst_core,
  input  logic        flush_req,
  input  logic        set_valid,
  input  logic [31:0] set_mask,
  output logic        set_ready,
  input  logic        clr_valid,
  input  logic [4:0]  clr_rd_addr,
  input  logic [31:0] query_mask,
  output logic        hazard,
  output logic [31:0] busy_mask,
  output logic        err
);

  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [31:0]      TRACKED  = 32'hFFFF_FFFE;

  logic [CNT_W-1:0] cnt_q [32];
  logic [CNT_W-1:0] cnt_d [32];
  logic [31:0]      busy_mask_q, busy_mask_d;
  logic [31:0]      sat_mask, inc_v, dec_v;
  logic             set_fire;

  always_comb begin
    for (int i = 0; i < 32; i++) begin
      sat_mask[i] = (cnt_q[i] == CNT_MAX);
    end
  end

  // Counter 0 never moves, so sat_mask[0] is always 0 and x0 never blocks issue.
  assign set_ready = ~rst_core & ~flush_req & ~|(set_mask & sat_mask);
  assign set_fire  = set_valid & set_ready;
  assign inc_v     = {32{set_fire}} & set_mask & TRACKED;
  assign dec_v     = (clr_valid ? (32'b1 << clr_rd_addr) : 32'b0) & TRACKED;

  always_comb begin
    for (int i = 0; i < 32; i++) begin
      cnt_d[i] = cnt_q[i];
      if (flush_req) begin
        cnt_d[i] = '0;
      end else if (inc_v[i] && !dec_v[i]) begin
        cnt_d[i] = cnt_q[i] + CNT_W'(1);
      end else if (dec_v[i] && !inc_v[i] && (cnt_q[i] != '0)) begin
        cnt_d[i] = cnt_q[i] - CNT_W'(1);
      end
      busy_mask_d[i] = (cnt_d[i] != '0);
    end
  end

  // NOTE: every counter is reset, not just the busy mask -- stale counts would resurface as hazards.
  always_ff @(posedge clk_core) begin
    if (rst_core) begin
      for (int i = 0; i < 32; i++) cnt_q[i] <= '0;
      busy_mask_q <= '0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      for (int i = 0; i < 32; i++) cnt_q[i] <= cnt_d[i];
      busy_mask_q <= busy_mask_d;
    end
  end

  assign busy_mask = busy_mask_q;
  assign hazard    = ~rst_core & |(query_mask & busy_mask_q);

`ifdef HSV_SCOREBOARD_ERR_EN
  localparam logic [CNT_W:0] WD_LIM = (CNT_W+1)'(2**CNT_W);

  logic [CNT_W:0] wd_q, wd_d;
  logic           err_q, err_d;
  logic           stall, uflow, x0_clr;

  assign stall  = set_valid & |(set_mask & sat_mask);
  assign uflow  = clr_valid & (clr_rd_addr != 5'd0) & (cnt_q[clr_rd_addr] == '0) &
                  ~inc_v[clr_rd_addr];
  assign x0_clr = clr_valid & (clr_rd_addr == 5'd0);

  always_comb begin
    wd_d  = stall ? ((wd_q == WD_LIM) ? wd_q : wd_q + 1'b1) : '0;
    // Watchdog fires on the (2^CNT_W + 1)-th consecutive stalled cycle.
    err_d = err_q | (stall & (wd_q == WD_LIM)) | (~flush_req & (uflow | x0_clr));
  end

  always_ff @(posedge clk_core) begin
    if (rst_core) begin
      wd_q  <= '0;
      err_q <= 1'b0;
    end else begin
      wd_q  <= wd_d;
      err_q <= err_d;
    end
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_hsv_core_issue_scoreboard.sv
// Self-checking bench for hsv_core_issue_scoreboard: directed scenarios then random traffic,
// all compared against a per-register counting model held in the bench.
module tb_hsv_core_issue_scoreboard;

  localparam int CNT_W = 2;
  localparam int MAXC  = (1 << CNT_W) - 1;

  logic        clk_core = 1'b0;
  logic        rst_core, flush_req, set_valid, clr_valid;
  logic [31:0] set_mask, query_mask, busy_mask;
  logic [4:0]  clr_rd_addr;
  logic        set_ready, hazard, err;

  int n_cmp  = 0;
  int n_fail = 0;

  // Reference model state
  int m_cnt [32];
  int m_run;
  bit m_err;

  always #5 clk_core = ~clk_core;

  hsv_core_issue_scoreboard #(.CNT_W(CNT_W)) dut (
    .clk_core   (clk_core),
    .rst_core   (rst_core),
    .flush_req  (flush_req),
    .set_valid  (set_valid),
    .set_mask   (set_mask),
    .set_ready  (set_ready),
    .clr_valid  (clr_valid),
    .clr_rd_addr(clr_rd_addr),
    .query_mask (query_mask),
    .hazard     (hazard),
    .busy_mask  (busy_mask),
    .err        (err)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] model_busy();
    logic [31:0] b = '0;
    for (int i = 1; i < 32; i++) b[i] = (m_cnt[i] != 0);
    return b;
  endfunction

  function automatic logic [31:0] model_sat();
    logic [31:0] s = '0;
    for (int i = 1; i < 32; i++) s[i] = (m_cnt[i] == MAXC);
    return s;
  endfunction

  // One clock cycle: drive, check combinational outputs, clock, advance model, check state.
  task automatic step(input logic sv, input logic [31:0] sm, input logic cv,
                      input logic [4:0] ca, input logic fl, input logic rs,
                      input logic [31:0] qm);
    logic exp_ready, stall, fire;
    set_valid = sv; set_mask = sm; clr_valid = cv; clr_rd_addr = ca;
    flush_req = fl; rst_core = rs; query_mask = qm;
    #1;
    stall     = sv && ((sm & model_sat()) != 0);
    exp_ready = !rs && !fl && ((sm & model_sat()) == 0);
    check("set_ready", {31'b0, set_ready}, {31'b0, exp_ready});
    check("hazard", {31'b0, hazard}, {31'b0, (!rs && ((qm & model_busy()) != 0))});
    @(posedge clk_core);
    fire = sv && exp_ready;
    if (rs) begin
      for (int i = 0; i < 32; i++) m_cnt[i] = 0;
      m_run = 0;
      m_err = 1'b0;
    end else begin
      m_run = stall ? m_run + 1 : 0;
`ifdef HSV_SCOREBOARD_ERR_EN
      if (m_run > (1 << CNT_W)) m_err = 1'b1;
      if (!fl && cv && ca == 0) m_err = 1'b1;
      if (!fl && cv && ca != 0 && m_cnt[ca] == 0 && !(fire && sm[ca])) m_err = 1'b1;
`endif
      for (int i = 1; i < 32; i++) begin
        int delta;
        delta = ((fire && sm[i]) ? 1 : 0) - ((cv && ca == i) ? 1 : 0);
        if (fl) m_cnt[i] = 0;
        else if (m_cnt[i] + delta >= 0) m_cnt[i] = m_cnt[i] + delta;
      end
    end
    #1;
    check("busy_mask", busy_mask, model_busy());
    check("err", {31'b0, err}, {31'b0, m_err});
  endtask

  task automatic idle(input logic [31:0] qm);
    step(1'b0, 32'h0, 1'b0, 5'd0, 1'b0, 1'b0, qm);
  endtask

  initial begin
    logic [4:0]  pool [5];
    logic [31:0] rm;
    pool[0] = 5'd0; pool[1] = 5'd3; pool[2] = 5'd5; pool[3] = 5'd7; pool[4] = 5'd31;
    for (int i = 0; i < 32; i++) m_cnt[i] = 0;
    m_run = 0;
    m_err = 1'b0;

    // Reset
    step(1'b0, 32'h0, 1'b0, 5'd0, 1'b0, 1'b1, 32'hFFFF_FFFF);
    step(1'b1, 32'h0000_8000, 1'b0, 5'd0, 1'b0, 1'b1, 32'hFFFF_FFFF);

    // x15 reservation and hazard queries
    step(1'b1, 32'h0000_8000, 1'b0, 5'd0, 1'b0, 1'b0, 32'h0000_8000);
    idle(32'h0000_8420);
    idle(32'h0000_0420);
    check("busy_x15", busy_mask, 32'h0000_8000);

    // Saturate x5, blocked 4th attempt, drain, then accept
    for (int k = 0; k < 4; k++) step(1'b1, 32'h20, 1'b0, 5'd0, 1'b0, 1'b0, 32'h20);
    check("busy5_held", {31'b0, busy_mask[5]}, 32'h1);
    step(1'b1, 32'h20, 1'b1, 5'd5, 1'b0, 1'b0, 32'h20); // saturated: set blocked, clear proceeds
    step(1'b1, 32'h20, 1'b0, 5'd0, 1'b0, 1'b0, 32'h20); // now accepted
    for (int k = 0; k < 3; k++) step(1'b0, 32'h0, 1'b1, 5'd5, 1'b0, 1'b0, 32'h20);
    check("busy5_clear", {31'b0, busy_mask[5]}, 32'h0);

    // Simultaneous set/clear of x10
    step(1'b1, 32'h400, 1'b0, 5'd0, 1'b0, 1'b0, 32'h400);
    step(1'b1, 32'h400, 1'b1, 5'd10, 1'b0, 1'b0, 32'h400);
    check("busy10_same", {31'b0, busy_mask[10]}, 32'h1);
    step(1'b0, 32'h0, 1'b1, 5'd10, 1'b0, 1'b0, 32'h400);
    check("busy10_drop", {31'b0, busy_mask[10]}, 32'h0);

    // x0 is never tracked; clearing x7 at zero is an underflow
    step(1'b1, 32'h1, 1'b0, 5'd0, 1'b0, 1'b0, 32'h1);
    step(1'b0, 32'h0, 1'b1, 5'd0, 1'b0, 1'b0, 32'h1);
    step(1'b0, 32'h0, 1'b1, 5'd7, 1'b0, 1'b0, 32'h80);

    // Flush with concurrent set of x20, then the same via reset
    step(1'b1, 32'h0000_8420, 1'b0, 5'd0, 1'b0, 1'b0, 32'h0);
    step(1'b1, 32'h0010_0000, 1'b0, 5'd0, 1'b1, 1'b0, 32'h0010_8420);
    check("flush_busy", busy_mask, 32'h0);
    step(1'b1, 32'h0000_8420, 1'b0, 5'd0, 1'b0, 1'b0, 32'h0);
    step(1'b1, 32'h0010_0000, 1'b0, 5'd0, 1'b0, 1'b1, 32'h0010_8420);
    check("reset_busy", busy_mask, 32'h0);

    // Underflow after reset, err sticky across flush
    step(1'b0, 32'h0, 1'b1, 5'd7, 1'b0, 1'b0, 32'h0);
    step(1'b0, 32'h0, 1'b0, 5'd0, 1'b1, 1'b0, 32'h0);
    idle(32'h0);

    // Watchdog: hold a blocked reservation on saturated x3
    step(1'b0, 32'h0, 1'b0, 5'd0, 1'b0, 1'b1, 32'h0);
    for (int k = 0; k < 3; k++) step(1'b1, 32'h8, 1'b0, 5'd0, 1'b0, 1'b0, 32'h8);
    for (int k = 0; k < 6; k++) step(1'b1, 32'h8, 1'b0, 5'd0, 1'b0, 1'b0, 32'h8);
    step(1'b0, 32'h0, 1'b0, 5'd0, 1'b0, 1'b1, 32'h0);

    // Random traffic concentrated on a few registers so saturation happens
    for (int n = 0; n < 500; n++) begin
      rm = '0;
      for (int b = 0; b < 5; b++) if ($urandom_range(2) == 0) rm[pool[b]] = 1'b1;
      if ($urandom_range(7) == 0) rm = rm | $urandom;
      step(1'($urandom_range(1)), rm, 1'($urandom_range(1)),
           ($urandom_range(3) == 0) ? 5'($urandom) : pool[$urandom_range(4)],
           ($urandom_range(39) == 0), ($urandom_range(79) == 0), $urandom);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
